ltc2195_decimator: RTL
======================

// Module: ltc2195_decimator
// PURPOSE
//   Consumes parallel samples from the LTC2195 front end: ADC0/ADC1 words plus the 4-bit frame nibble, one sample per clk_in.
//   Checks every frame nibble against the expected pattern and counts mismatches.
//   Boxcar-averages each channel over 2^N samples and emits one averaged pair per block with a one-cycle valid strobe.
//   Sits between the ADC controller and the servo/loop-filter logic; N is set over the shared command bus.
// PARAMETERS
//   FR_PATTERN  4'b0011  expected FR nibble for an aligned sample
//   FR_GOOD     4        consecutive good frames required to leave ALIGN (1..15)
//   LOG2_MAX    8        maximum decimation exponent N; ACC_W = 16+LOG2_MAX
//   DEFAULT_N   0        decimation exponent after reset (<= LOG2_MAX)
// PORTS
//   clk_in         in   1   system clock, one ADC sample per cycle
//   rst_in         in   1   synchronous, active-high reset
//   cmd_trig_in    in   1   command strobe, one cycle
//   cmd_addr_in    in   16  command address; block decodes 16'h33??
//   cmd_data_in    in   16  command data
//   adc0_in        in   16  signed ADC0 sample, two's complement
//   adc1_in        in   16  signed ADC1 sample
//   fr_in          in   4   frame nibble for the same sample
//   adc0_out       out  16  signed averaged ADC0
//   adc1_out       out  16  signed averaged ADC1
//   valid_out      out  1   one-cycle strobe: new adc0_out/adc1_out
//   aligned_out    out  1   high while in RUN
//   frame_err_out  out  1   sticky: any mismatch since last clear
//   err_count_out  out  16  mismatch count, saturates at 16'hFFFF
// BEHAVIOUR
//   Reset (rst_in high at posedge): all outputs 0, N=DEFAULT_N, accumulators, sample counter and good-frame counter cleared, state ALIGN.
//   Input stage: adc0_in, adc1_in and fr_in are registered on every cycle (stage 1); all logic below acts on stage-1 values.
//   Frame check: mismatch = (fr_s1 != FR_PATTERN), evaluated every cycle in both states.
//     On mismatch: err_count_out += 1 (saturating); frame_err_out <= 1.
//   FSM ALIGN:
//     A good frame increments good_cnt; a mismatch clears good_cnt.
//     When good_cnt reaches FR_GOOD-1 and the current frame is good, go to RUN with acc and sample count cleared.
//     No accumulation and no valid_out in ALIGN.
//   FSM RUN:
//     A good frame is accumulated: acc0 += sext(adc0_s1), acc1 += sext(adc1_s1), cnt += 1.
//     When cnt == 2^N-1 on a good frame: adc*_out <= (acc + sample) >>> N (arithmetic; floor), valid_out <= 1; acc and cnt cleared.
//     A mismatch goes to ALIGN: partial block discarded, no valid_out, good_cnt = 0.
//   Latency: last sample of a block on adc*_in at cycle t -> valid_out and data at t+2. N=0 gives one output every cycle.
//   adc*_out hold their value between strobes. valid_out is low on all other cycles.
//   ACC_W bits: no overflow possible for 2^LOG2_MAX samples of 16 bits; the shifted result always fits in 16 bits.
//   Commands (accepted in any state when cmd_trig_in && cmd_addr_in[15:8]==8'h33):
//     addr[7:0]=8'h00: N <= min(cmd_data_in[3:0], LOG2_MAX); acc and cnt cleared on the next cycle; no valid_out for the partial block.
//     addr[7:0]=8'h01: err_count_out and frame_err_out cleared.
//       If a mismatch occurs in the same cycle, count becomes 1 and the flag becomes 1.
//     Other low bytes are ignored. Commands for other address pages are ignored.
//   A decimation write coinciding with block completion: the completing block is still output; the new N applies to the next block.
//   Reset mid-block discards everything; the first valid_out requires ALIGN to be passed again.
// CONFIGURATION
//   DECIM_ROUND_EN defined: for N>0, add 2^(N-1) to acc before >>>N (round half up). For N=0 the result is unchanged.
//   DECIM_ROUND_EN undefined: plain arithmetic shift (floor). All other behaviour is identical.
// TESTING
//   1. Reset, fr_in=4'b0011 constantly, N=0, adc0_in ramps 0,1,2.
//      -> aligned_out high after FR_GOOD good frames; valid_out every cycle; adc0_out echoes input 2 cycles late.
//   2. Write 16'h3300 with data 3; adc0_in alternates 100/-100, adc1_in=-7 constant.
//      -> valid_out once per 8 cycles; adc0_out=0, adc1_out=-7.
//   3. N=1, adc0_in=1,2 repeating.
//      -> adc0_out=1 without DECIM_ROUND_EN; adc0_out=2 with DECIM_ROUND_EN.
//   4. In RUN, inject fr_in=4'b0110 for one cycle mid-block.
//      -> partial block dropped; aligned_out low for FR_GOOD cycles; err_count_out=1; frame_err_out=1.
//   5. Write 16'h3301 in the same cycle as a stage-1 mismatch -> err_count_out=1. Write 16'h3301 with no mismatch -> err_count_out=0, frame_err_out=0.
//   6. Write 16'h3300 with data 15 while LOG2_MAX=8 -> N=8 (clamped); 256 samples of 16'h7FFF -> adc0_out=16'h7FFF.

Source files
------------

// File: rtl/ltc2195_decimator_if.sv
// ltc2195_decimator_if
//   Groups the command bus, the LTC2195 sample stream and the averaged
//   output stream of ltc2195_decimator into one bundle.
//   Signals:
//     cmd_trig_in / cmd_addr_in / cmd_data_in : shared command bus (to decimator)
//     adc0_in / adc1_in / fr_in               : raw sample pair + frame nibble (to decimator)
//     adc0_out / adc1_out / valid_out         : averaged pair + one-cycle strobe (from decimator)
//     aligned_out / frame_err_out / err_count_out : frame alignment status (from decimator)
//   Modports:
//     slave  : the decimator side
//     master : the driving side (ADC controller / command master / bench)
interface ltc2195_decimator_if;
  logic        cmd_trig_in;
  logic [15:0] cmd_addr_in;
  logic [15:0] cmd_data_in;
  logic [15:0] adc0_in;
  logic [15:0] adc1_in;
  logic [3:0]  fr_in;
  logic [15:0] adc0_out;
  logic [15:0] adc1_out;
  logic        valid_out;
  logic        aligned_out;
  logic        frame_err_out;
  logic [15:0] err_count_out;

  modport slave (
    input  cmd_trig_in, cmd_addr_in, cmd_data_in, adc0_in, adc1_in, fr_in,
    output adc0_out, adc1_out, valid_out, aligned_out, frame_err_out, err_count_out
  );

  modport master (
    output cmd_trig_in, cmd_addr_in, cmd_data_in, adc0_in, adc1_in, fr_in,
    input  adc0_out, adc1_out, valid_out, aligned_out, frame_err_out, err_count_out
  );
endinterface

// File: rtl/ltc2195_decimator.sv
// ltc2195_decimator
//   Takes one LTC2195 sample pair plus frame nibble per clock, checks every
//   frame nibble against FR_PATTERN, and boxcar-averages both channels over
//   2^N samples, producing one averaged pair per block with a valid strobe.
//   Optional feature macro: DECIM_ROUND_EN (round half up instead of floor).
//   Ports:
//     clk_in : system clock, one sample per cycle
//     rst_in : synchronous active-high reset
//     bus    : ltc2195_decimator_if.slave (command bus, samples in, averages
//              and alignment status out)
module ltc2195_decimator #(
  parameter logic [3:0] FR_PATTERN = 4'b0011,
  parameter int         FR_GOOD    = 4,
  parameter int         LOG2_MAX   = 8,
  parameter int         DEFAULT_N  = 0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  ltc2195_decimator_if.slave    bus
);

  localparam int ACC_W = 16 + LOG2_MAX;
  localparam int CNT_W = LOG2_MAX + 1;
  localparam logic [3:0] N_MAX     = 4'(LOG2_MAX);
  localparam logic [3:0] N_RST     = 4'(DEFAULT_N);
  localparam logic [3:0] GOOD_LAST = 4'(FR_GOOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  typedef enum logic {ST_ALIGN, ST_RUN} state_t;

  // Stage-1 copies of the ADC inputs; everything else works on these.
  logic [15:0] r_adc0_s1;
  logic [15:0] r_adc1_s1;
  logic [3:0]  r_fr_s1;

  state_t                   r_state;
  logic [3:0]               r_good_cnt;
  logic [3:0]               r_n;
  logic signed [ACC_W-1:0]  r_acc0;
  logic signed [ACC_W-1:0]  r_acc1;
  logic [CNT_W-1:0]         r_cnt;

  logic [15:0] r_adc0_out;
  logic [15:0] r_adc1_out;
  logic        r_valid;
  logic        r_aligned;
  logic        r_frame_err;
  logic [15:0] r_err_count;

  logic                    w_mismatch;
  logic                    w_cmd_hit;
  logic                    w_wr_n;
  logic                    w_clr_err;
  logic [3:0]              w_new_n;
  logic signed [ACC_W-1:0] w_samp0;
  logic signed [ACC_W-1:0] w_samp1;
  logic signed [ACC_W-1:0] w_sum0;
  logic signed [ACC_W-1:0] w_sum1;
  logic signed [ACC_W-1:0] w_bias;
  logic [CNT_W-1:0]        w_cnt_last;

  assign w_mismatch = (r_fr_s1 != FR_PATTERN);
  assign w_cmd_hit  = bus.cmd_trig_in && (bus.cmd_addr_in[15:8] == 8'h33);
  assign w_wr_n     = w_cmd_hit && (bus.cmd_addr_in[7:0] == 8'h00);
  assign w_clr_err  = w_cmd_hit && (bus.cmd_addr_in[7:0] == 8'h01);
  assign w_new_n    = (bus.cmd_data_in[3:0] > N_MAX) ? N_MAX : bus.cmd_data_in[3:0];

  assign w_samp0 = {{LOG2_MAX{r_adc0_s1[15]}}, r_adc0_s1};
  assign w_samp1 = {{LOG2_MAX{r_adc1_s1[15]}}, r_adc1_s1};
  assign w_sum0  = r_acc0 + w_samp0;
  assign w_sum1  = r_acc1 + w_samp1;

  // Index of the last sample in a block of 2^N.
  assign w_cnt_last = (CNT_ONE << r_n) - CNT_ONE;

`ifdef DECIM_ROUND_EN
  // Half an output LSB added before the shift turns floor into round-half-up.
  assign w_bias = (r_n == 4'd0) ? '0 : (ACC_ONE << (r_n - 4'd1));
`else
  assign w_bias = '0;
`endif

  // Input stage: capture the raw sample every cycle, reset included, so the
  // first post-reset frame check sees a real nibble rather than a forced zero.
  always_ff @(posedge clk_in) begin
    r_adc0_s1 <= bus.adc0_in;
    r_adc1_s1 <= bus.adc1_in;
    r_fr_s1   <= bus.fr_in;
  end

  // Frame error bookkeeping. A clear that lands on a mismatching frame still
  // records that frame, so nothing is lost across the clear.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_err_count <= 16'd0;
      r_frame_err <= 1'b0;
    end else if (w_clr_err) begin
      r_err_count <= w_mismatch ? 16'd1 : 16'd0;
      r_frame_err <= w_mismatch;
    end else if (w_mismatch) begin
      if (r_err_count != 16'hFFFF) begin
        r_err_count <= r_err_count + 16'd1;
      end
      r_frame_err <= 1'b1;
    end
  end

  // Decimation exponent, clamped so the accumulator can never overflow.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_n <= N_RST;
    end else if (w_wr_n) begin
      r_n <= w_new_n;
    end
  end

  // Alignment FSM and block accumulator. A completing block takes priority
  // over an N write so that block is still delivered with the old N; an N
  // write otherwise throws away the partial block.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= ST_ALIGN;
      r_good_cnt <= 4'd0;
      r_acc0     <= '0;
      r_acc1     <= '0;
      r_cnt      <= '0;
      r_adc0_out <= 16'd0;
      r_adc1_out <= 16'd0;
      r_valid    <= 1'b0;
      r_aligned  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_ALIGN: begin
          r_acc0 <= '0;
          r_acc1 <= '0;
          r_cnt  <= '0;
          if (w_mismatch) begin
            r_good_cnt <= 4'd0;
          end else if (r_good_cnt == GOOD_LAST) begin
            r_good_cnt <= 4'd0;
            r_state    <= ST_RUN;
            r_aligned  <= 1'b1;
          end else begin
            r_good_cnt <= r_good_cnt + 4'd1;
          end
        end
        ST_RUN: begin
          if (w_mismatch) begin
            r_state    <= ST_ALIGN;
            r_aligned  <= 1'b0;
            r_good_cnt <= 4'd0;
            r_acc0     <= '0;
            r_acc1     <= '0;
            r_cnt      <= '0;
          end else if (r_cnt == w_cnt_last) begin
            r_adc0_out <= 16'((w_sum0 + w_bias) >>> r_n);
            r_adc1_out <= 16'((w_sum1 + w_bias) >>> r_n);
            r_valid    <= 1'b1;
            r_acc0     <= '0;
            r_acc1     <= '0;
            r_cnt      <= '0;
          end else if (w_wr_n) begin
            r_acc0 <= '0;
            r_acc1 <= '0;
            r_cnt  <= '0;
          end else begin
            r_acc0 <= w_sum0;
            r_acc1 <= w_sum1;
            r_cnt  <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_ALIGN;
        end
      endcase
    end
  end

  assign bus.adc0_out      = r_adc0_out;
  assign bus.adc1_out      = r_adc1_out;
  assign bus.valid_out     = r_valid;
  assign bus.aligned_out   = r_aligned;
  assign bus.frame_err_out = r_frame_err;
  assign bus.err_count_out = r_err_count;

endmodule
